// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple carry adder: the only arithmetic in the serial adder.
module RippleCarryAdder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder sequencer: one 4-bit slice per clock through a single
// 4-bit ripple adder, inter-nibble carry held in a flop.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN,
// which adds the op_sub port.
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW      = $clog2(NIBBLES) + 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_chk
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t                state;
    logic [WIDTH-1:0]      a_sh;
    logic [WIDTH-1:0]      b_sh;
    logic [WIDTH-1:0]      work;
    logic [WIDTH-1:0]      work_nxt;
    logic                  carry;
    logic [CW-1:0]         cnt;
    logic                  a_msb;
    logic                  b_msb;
    logic [WIDTH-1:0]      b_eff;
    logic                  c_eff;
    logic [NIBBLE_W-1:0]   nib_s;
    logic                  nib_c;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract is A + ~B + 1; the caller's cin is ignored in that mode.
    assign b_eff = op_sub ? ~b : b;
    assign c_eff = op_sub ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    RippleCarryAdder_4bit u_rca (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry),
        .sum  (nib_s),
        .cout (nib_c)
    );

    // New sum nibble enters at the top; after NIBBLES shifts the word is complete.
    if (NIBBLES > 1) begin : g_work_multi
        assign work_nxt = {nib_s, work[WIDTH-1:NIBBLE_W]};
    end else begin : g_work_single
        assign work_nxt = nib_s;
    end

    // Handshake flags come straight from state, never from inputs.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Sequencer: accept, step one nibble per cycle, then hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            work     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b_eff;
                        carry <= c_eff;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b_eff[WIDTH-1];
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> NIBBLE_W;
                    b_sh  <= b_sh >> NIBBLE_W;
                    work  <= work_nxt;
                    carry <= nib_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(NIBBLES - 1)) begin
                        sum      <= work_nxt;
                        cout     <= nib_c;
                        // Same-sign operands whose sum flips sign overflowed.
                        overflow <= (a_msb == b_msb) && (nib_s[NIBBLE_W-1] != a_msb);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic        op_sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge with the DUT in IDLE; leaves it in IDLE the same way.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts,
                         input logic [15:0] es, input logic ec, input logic eo);
        int n;
        a = ta; b = tb_v; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
        op_sub = ts;
`else
        if (ts) $display("note: %s needs subtract support, skipped", tag);
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'h2);
`ifdef SERIAL_ADDER_SUB_EN
        op_sub = 1'b0;
`endif
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        op_sub = 1'b0;
`endif
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", {30'd0, cout, overflow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Reset in the 2nd RUN cycle drops the operation and clears the held result.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_sum", 32'(sum), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("flush_no_result", 32'(n), 32'd0);

        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("ripple_cin", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        do_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("mixed", 16'hA5C3, 16'h5A3D, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure: result held while out_ready low, in_valid ignored.
        a = 16'h00F0; b = 16'h0F00; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h0001; b = 16'h0002;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_lat", 32'(n), 32'd4);
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || sum !== 16'h0FF0) n++;
        end
        chk("bp_hold", 32'(n), 32'd0);
        chk("bp_sum", 32'(sum), 32'h0FF0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", {30'd0, in_ready, out_valid}, 32'h2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_next_lat", 32'(n), 32'd4);
        chk("bp_next_sum", 32'(sum), 32'h0003);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_cin_ign", 16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle, nibble-serial adder sequencer for WIDTH-bit operands, built around the team's 4-bit ripple carry adder. It accepts one operand pair over a valid/ready handshake. It feeds one 4-bit slice per clock into a single 4-bit adder instance, carrying the inter-nibble carry in a flop. It returns the assembled sum, carry-out and signed overflow over a second valid/ready handshake. It trades latency for area wherever a full-width adder is not justified.

## Interface
- WIDTH, 16: operand/result width in bits.
  - Must be a multiple of 4 and ≥ 4; any other value is an elaboration error.
  - NIBBLES = WIDTH/4.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into nibble 0.
- op_sub  in  1  1 = A − B. Present only with SERIAL_ADDER_SUB_EN.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the top nibble.
- overflow  out  1  two's-complement overflow.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready: latch a and b (effective B) into shift registers, load the carry flop with cin (effective), clear the nibble counter, go to RUN.
  - Latch the MSBs of A and effective B for overflow.
- **RUN**
  - in_ready = 0.
  - Each cycle, the adder sums the low nibble of A_sh and B_sh plus the carry flop.
  - The sum nibble shifts into the top of the working register; A_sh and B_sh shift right by 4.
  - The carry flop takes the adder's Cout; the counter increments.
  - On the cycle the counter equals NIBBLES−1:
    - Load the result registers: sum = completed working value, cout = final carry.
    - overflow = (a_msb == beff_msb) && (sum_msb != a_msb).
    - Go to DONE.
- **DONE**
  - out_valid = 1; in_ready = 0.
  - in_valid is ignored.
  - On out_ready, go to IDLE.
- **Result hold:** sum, cout and overflow are held from their DONE load until the next operation's DONE load. They are not disturbed during IDLE or RUN.
- **Reset values:** in_ready = 1 (IDLE), out_valid = 0, sum = 0, cout = 0, overflow = 0. Shift registers, carry flop and counter also reset to 0.
- **Reset asserted mid-RUN or in DONE:** the operation is dropped, all state returns to reset values immediately (asynchronous), and there is no partial result.
- **Arithmetic:** the result is modulo 2^WIDTH; cout is the true carry out of bit WIDTH−1.
- **Counter width:** $clog2(NIBBLES)+1 bits. The counter never wraps within an operation.

## Timing
- **Latency:** out_valid rises exactly NIBBLES clock edges after the accepting edge. For WIDTH=16 that is 4 cycles.
- **Throughput:** one operation per NIBBLES+2 cycles when out_ready is held high.
  - The DONE→IDLE edge happens on the edge where out_ready is sampled high.
  - Acceptance happens on the next edge at the earliest.
- **Outputs:** in_ready and out_valid are decoded from state registers only, with no combinational path from inputs.
- **Simultaneous events:** in_valid in DONE concurrent with out_ready is not accepted that edge; it is accepted from IDLE one edge later.
- **Backpressure:** out_valid stays high and sum is stable for any number of cycles while out_ready = 0.

## Configuration
- **SERIAL_ADDER_SUB_EN defined:**
  - op_sub port exists and is latched at acceptance.
  - When op_sub = 1, effective B = ~b and the initial carry is forced to 1 (cin ignored).
  - cout = 1 means no borrow.
- **SERIAL_ADDER_SUB_EN undefined:**
  - No op_sub port; effective B = b and initial carry = cin.

## Structure
- **Shared package nibble_serial_pkg:**
  - NIBBLE_W = 4.
  - State typedef: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - Illegal state 2'b11 recovers to IDLE.
- **Sub-module:** one instance of RippleCarryAdder_4bit is the only arithmetic. No WIDTH-wide adder is permitted.

## Test plan
- **Reset and flush:** WIDTH=16, accept a=16'h1234, b=16'h4321, pulse rst_n low in the 2nd RUN cycle -> out_valid = 0 and in_ready = 1 immediately, sum = 0, no result afterwards.
- **Basic add:** a=16'h1234, b=16'h4321, cin=0 -> after 4 cycles out_valid = 1, sum = 16'h5555, cout = 0, overflow = 0.
- **Full carry ripple across nibbles:** a=16'hFFFF, b=16'h0001, cin=0 -> sum = 16'h0000, cout = 1, overflow = 0. Same operands with cin=1 -> sum = 16'h0001, cout = 1.
- **Signed overflow:** a=16'h7FFF, b=16'h0001 -> sum = 16'h8000, cout = 0, overflow = 1.
- **Backpressure:** result ready with out_ready = 0 for 5 cycles while in_valid = 1 -> sum is held, in_ready = 0, nothing accepted. Raise out_ready -> IDLE next edge, new pair accepted the edge after.
- **SERIAL_ADDER_SUB_EN:** op_sub=1, a=16'h0005, b=16'h0007 -> sum = 16'hFFFE, cout = 0. With a=16'h8000, b=16'h0001 -> sum = 16'h7FFF, overflow = 1.
